// File: rtl/fir_decim_out.sv
// Block-averaging output stage for the 4-tap FIR: sums DECIM samples, shifts by LOG2_DECIM, buffers in a show-ahead FIFO.
// Define FIR_DECIM_APPROX_EN to build the accumulator with the approximate-LSB adder.
module fir_decim_out #(
    parameter int DECIM      = 4,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Xin,
    input  logic        Xvalid,
    output logic [15:0] Yout,
    output logic        Yvalid,
    input  logic        Yready,
    output logic        Overflow
);

    localparam int W  = 16 + LOG2_DECIM;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Approximate variant: no carry out of the low 3 bits, low bits forced to 3'b111 when bit 3 differs.
    function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef FIR_DECIM_APPROX_EN
        logic [W-1:0] s;
        s[W-1:3] = a[W-1:3] + b[W-1:3];
        s[2:0]   = (a[3] ^ b[3]) ? 3'b111 : (a[2:0] + b[2:0]);
        return s;
`else
        return a + b;
`endif
    endfunction

    logic [W-1:0]          acc_q, acc_d;
    logic [LOG2_DECIM-1:0] phase_q, phase_d;
    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [15:0]           mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic [W-1:0] xin_ext;
    logic [W-1:0] sum;
    logic [15:0]  result;
    logic         block_done;
    logic         full;
    logic         pop;
    logic         push;

    assign xin_ext    = {{LOG2_DECIM{Xin[15]}}, Xin};
    assign sum        = acc_add(acc_q, xin_ext);
    assign result     = sum[W-1:LOG2_DECIM];
    assign block_done = Xvalid && (phase_q == LOG2_DECIM'(DECIM - 1));
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (count_q != '0) && Yready;
    // A full FIFO still accepts a block that completes in the same cycle as a pop.
    assign push       = block_done && (!full || pop);

    always_comb begin
        acc_d      = acc_q;
        phase_d    = phase_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (Xvalid) begin
            if (block_done) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + LOG2_DECIM'(1);
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (block_done && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc_q      <= '0;
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign Yout     = mem_q[rd_ptr_q];
    assign Yvalid   = (count_q != '0);
    assign Overflow = overflow_q;

endmodule
